ccff_loader: RTL and testbench

Bitstream loader that feeds the configuration chain built from the DFF/DFFSRQ cells.
- Accepts configuration words from an upstream source (SPI/UART bridge) over a valid/ready handshake.
- Serialises each word MSB-first onto the chain head with a one-cycle shift strobe per bit.
- Counts exactly CHAIN_LEN bits, then flags completion.

---
 rtl/ccff_loader.sv | 145 ++++++++++++++
 tb/tb_ccff_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_loader.sv
// ccff_loader
// Bitstream loader for the configuration flop chain. Accepts configuration
// words over a valid/ready handshake and serialises each one MSB-first onto
// the chain head. It issues one shift strobe per bit and stops after exactly
// CHAIN_LEN bits.
//
// Ports:
//   ck          system clock (shared with the chain flops)
//   rst_n       asynchronous active-low reset
//   start       one-cycle pulse that begins a load (honoured in idle/done only)
//   abort       synchronous abort; highest priority, returns to idle
//   in_data     configuration word (DATA_W bits)
//   in_valid    upstream word valid
//   in_ready    loader can accept a word (high only while fetching)
//   ccff_head   serial bit into the chain head (registered)
//   ccff_shift  chain shift enable; the chain captures ccff_head when high
//   busy        load in progress
//   done        chain fully loaded; held until the next start or reset
module ccff_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int DATA_W    = 8
) (
  input  logic              ck,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              ccff_shift,
  output logic              busy,
  output logic              done
);

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int WW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    st_idle,
    st_fetch,
    st_shift,
    st_done
  } state_t;

  state_t            state_reg;
  logic [BW-1:0]     bitcnt_reg;
  logic [WW-1:0]     wcnt_reg;
  logic [DATA_W-1:0] sr_reg;

  logic [DATA_W-1:0] sr_shl;
  logic [31:0]       rem_bits;
  logic [WW-1:0]     wcnt_load;
  logic              last_bit;

  assign sr_shl = sr_reg << 1;

  // Bits still owed to the chain decide how much of the next word is used;
  // on a partial last word only its top bits are shifted out.
  always_comb begin
    rem_bits  = 32'(CHAIN_LEN) - 32'(bitcnt_reg);
    wcnt_load = WW'(DATA_W);
    if (rem_bits < 32'(DATA_W)) begin
      wcnt_load = WW'(rem_bits);
    end
  end

  assign last_bit = ((32'(bitcnt_reg) + 32'd1) == 32'(CHAIN_LEN));

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= st_idle;
      bitcnt_reg <= '0;
      wcnt_reg   <= '0;
      sr_reg     <= '0;
      in_ready   <= 1'b0;
      ccff_head  <= 1'b0;
      ccff_shift <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (abort) begin
      state_reg  <= st_idle;
      bitcnt_reg <= '0;
      wcnt_reg   <= '0;
      sr_reg     <= '0;
      in_ready   <= 1'b0;
      ccff_head  <= 1'b0;
      ccff_shift <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_reg)
        st_idle, st_done: begin
          if (start) begin
            state_reg  <= st_fetch;
            bitcnt_reg <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            in_ready   <= 1'b1;
          end
        end

        st_fetch: begin
          // in_ready is known high in this state, so in_valid completes
          // the handshake.
          if (in_valid) begin
            state_reg  <= st_shift;
            sr_reg     <= in_data;
            wcnt_reg   <= wcnt_load;
            in_ready   <= 1'b0;
            ccff_shift <= 1'b1;
            // Head is a flop, so preload it with the first bit to be shifted.
            ccff_head  <= in_data[DATA_W-1];
          end
        end

        st_shift: begin
          sr_reg     <= sr_shl;
          bitcnt_reg <= bitcnt_reg + BW'(1);
          wcnt_reg   <= wcnt_reg - WW'(1);
          if (wcnt_reg == WW'(1)) begin
            ccff_shift <= 1'b0;
            ccff_head  <= 1'b0;
            if (last_bit) begin
              state_reg <= st_done;
              busy      <= 1'b0;
              done      <= 1'b1;
              sr_reg    <= '0;
            end else begin
              state_reg <= st_fetch;
              in_ready  <= 1'b1;
            end
          end else begin
            ccff_head <= sr_shl[DATA_W-1];
          end
        end

        default: begin
          state_reg <= st_idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader: a 16-bit chain and a 12-bit chain, both
// with 8-bit words. Inputs are driven and outputs sampled on the falling
// edge.
module tb_ccff_loader;

  logic       ck;
  logic       rst_n;

  logic       start, abort, in_valid;
  logic [7:0] in_data;
  logic       in_ready, ccff_head, ccff_shift, busy, done;

  logic       start2, abort2, in_valid2;
  logic [7:0] in_data2;
  logic       in_ready2, ccff_head2, ccff_shift2, busy2, done2;

  int checks = 0;
  int errors = 0;

  ccff_loader #(.CHAIN_LEN(16), .DATA_W(8)) dut16 (
    .ck(ck), .rst_n(rst_n), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ccff_head(ccff_head), .ccff_shift(ccff_shift), .busy(busy), .done(done)
  );

  ccff_loader #(.CHAIN_LEN(12), .DATA_W(8)) dut12 (
    .ck(ck), .rst_n(rst_n), .start(start2), .abort(abort2),
    .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .ccff_head(ccff_head2), .ccff_shift(ccff_shift2), .busy(busy2), .done(done2)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One load on the 16-bit chain. Word stream is w0, w1, then filler (still
  // valid, so any extra handshake is counted). stall: cycles in_valid is held
  // low before the second word. start_at / abort_at: pulse start / abort
  // while at that many shifted bits (-1 = never).
  task automatic load16(input logic [7:0] w0, input logic [7:0] w1,
                        input int stall, input int start_at, input int abort_at,
                        output logic [15:0] stream, output int nshift,
                        output int nhs, output int done_cyc, output int gap);
    int widx, stalled, cyc;
    bit abort_sent, start_sent;
    stream = '0; nshift = 0; nhs = 0; done_cyc = -1; gap = 0;
    widx = 0; stalled = 0; abort_sent = 0; start_sent = 0;
    @(negedge ck);
    start = 1'b1; in_valid = 1'b0;
    @(posedge ck);
    @(negedge ck);
    start = 1'b0;
    for (cyc = 1; cyc < 80; cyc++) begin
      if (abort_sent) begin
        abort = 1'b0;
        break;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (ccff_shift) begin
        stream = {stream[14:0], ccff_head};
        nshift++;
      end
      if (in_ready && nshift > 0) gap++;
      start = 1'b0;
      if (start_at >= 0 && !start_sent && ccff_shift && nshift == start_at) begin
        start = 1'b1;
        start_sent = 1;
      end
      if (abort_at >= 0 && nshift == abort_at) begin
        abort = 1'b1;
        abort_sent = 1;
      end
      in_valid = 1'b1;
      if (widx == 1 && in_ready && stalled < stall) begin
        in_valid = 1'b0;
        stalled++;
      end
      in_data = (widx == 0) ? w0 : (widx == 1) ? w1 : 8'hEE;
      if (in_ready && in_valid && !abort) begin
        nhs++;
        widx++;
      end
      @(posedge ck);
      @(negedge ck);
    end
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] stream;
    int nshift, nhs, done_cyc, gap, ones;

    rst_n = 1'b0;
    start = 0; abort = 0; in_valid = 0; in_data = 0;
    start2 = 0; abort2 = 0; in_valid2 = 0; in_data2 = 0;

    // 1. Reset held: outputs stay 0 while inputs toggle.
    for (int i = 0; i < 4; i++) begin
      @(negedge ck);
      start = 1'($urandom); abort = 1'($urandom); in_valid = 1'b1;
      in_data = 8'($urandom); start2 = ~start; in_valid2 = 1'b1;
      @(negedge ck);
      check("reset_outs16", {27'd0, in_ready, ccff_head, ccff_shift, busy, done}, 32'd0);
      check("reset_outs12", {27'd0, in_ready2, ccff_head2, ccff_shift2, busy2, done2}, 32'd0);
    end
    start = 0; abort = 0; in_valid = 0; start2 = 0; in_valid2 = 0;
    @(negedge ck);
    rst_n = 1'b1;
    @(negedge ck);
    @(negedge ck);
    check("idle_outs", {27'd0, in_ready, ccff_head, ccff_shift, busy, done}, 32'd0);

    // Reset asserted mid-cycle during shift: outputs drop without a clock edge.
    start = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    @(negedge ck);
    start = 1'b0;
    @(negedge ck);
    check("pre_reset_shift", {31'd0, ccff_shift}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outs", {27'd0, in_ready, ccff_head, ccff_shift, busy, done}, 32'd0);
    in_valid = 1'b0;
    @(negedge ck);
    rst_n = 1'b1;
    @(negedge ck);

    // 2. Basic 16-bit load, upstream always valid.
    load16(8'hA5, 8'h3C, 0, -1, -1, stream, nshift, nhs, done_cyc, gap);
    $display("load A5,3C: stream=%h shifts=%0d hs=%0d gap=%0d done_cyc=%0d", stream, nshift, nhs, gap, done_cyc);
    check("s2_stream", 32'(stream), 32'h0000A53C);
    check("s2_shifts", nshift, 16);
    check("s2_handshakes", nhs, 2);
    check("s2_gap", gap, 1);
    check("s2_done_cycle", done_cyc, 19);
    check("s2_busy", {31'd0, busy}, 32'd0);
    check("s2_done", {31'd0, done}, 32'd1);

    // 3. Backpressure: 5 idle cycles before the second word.
    load16(8'hA5, 8'h3C, 5, -1, -1, stream, nshift, nhs, done_cyc, gap);
    $display("load stall5: stream=%h shifts=%0d hs=%0d gap=%0d done_cyc=%0d", stream, nshift, nhs, gap, done_cyc);
    check("s3_stream", 32'(stream), 32'h0000A53C);
    check("s3_shifts", nshift, 16);
    check("s3_handshakes", nhs, 2);
    check("s3_gap", gap, 6);
    check("s3_done_cycle", done_cyc, 24);

    // 4. 12-bit chain, partial last word.
    @(negedge ck);
    start2 = 1'b1;
    @(posedge ck);
    @(negedge ck);
    start2 = 1'b0;
    nshift = 0; nhs = 0; ones = 0; done_cyc = -1;
    for (int cyc = 1; cyc < 60; cyc++) begin
      if (ccff_shift2) begin
        nshift++;
        if (ccff_head2) ones++;
      end
      if (done2 && done_cyc < 0) done_cyc = cyc;
      in_valid2 = 1'b1;
      in_data2 = (nhs == 0) ? 8'hFF : (nhs == 1) ? 8'hF0 : 8'h0F;
      if (in_ready2 && in_valid2) nhs++;
      @(posedge ck);
      @(negedge ck);
    end
    in_valid2 = 1'b0;
    $display("load12 FF,F0: shifts=%0d ones=%0d hs=%0d done_cyc=%0d", nshift, ones, nhs, done_cyc);
    check("s4_shifts", nshift, 12);
    check("s4_ones", ones, 12);
    check("s4_handshakes", nhs, 2);
    check("s4_done_cycle", done_cyc, 15);
    check("s4_done", {31'd0, done2}, 32'd1);

    // 5a. start pulsed mid-shift is ignored.
    load16(8'hA5, 8'h3C, 0, 3, -1, stream, nshift, nhs, done_cyc, gap);
    $display("load start-mid-shift: stream=%h done_cyc=%0d", stream, done_cyc);
    check("s5_start_ign_stream", 32'(stream), 32'h0000A53C);
    check("s5_start_ign_done_cycle", done_cyc, 19);

    // 5b. abort after 5 bits.
    load16(8'hA5, 8'h3C, 0, -1, 5, stream, nshift, nhs, done_cyc, gap);
    $display("load abort@5: shifts=%0d stream=%h", nshift, stream);
    check("s5_abort_bits", nshift, 5);
    check("s5_abort_outs", {27'd0, in_ready, ccff_head, ccff_shift, busy, done}, 32'd0);
    @(negedge ck);
    check("s5_abort_idle", {27'd0, in_ready, ccff_head, ccff_shift, busy, done}, 32'd0);

    // 5c. fresh load after abort.
    load16(8'hA5, 8'h3C, 0, -1, -1, stream, nshift, nhs, done_cyc, gap);
    $display("load after abort: stream=%h done_cyc=%0d", stream, done_cyc);
    check("s5_reload_stream", 32'(stream), 32'h0000A53C);
    check("s5_reload_done_cycle", done_cyc, 19);

    // 6. Reload from done; done must clear at the start edge.
    check("s6_done_before", {31'd0, done}, 32'd1);
    load16(8'h00, 8'hFF, 0, -1, -1, stream, nshift, nhs, done_cyc, gap);
    $display("reload 00,FF: stream=%h done_cyc=%0d", stream, done_cyc);
    check("s6_stream", 32'(stream), 32'h000000FF);
    check("s6_done_cycle", done_cyc, 19);
    check("s6_done", {31'd0, done}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
